// File: rtl/tcm4671_pkg.sv
// Shared types and datagram field positions for the TMC4671-style SPI responder.
// A datagram is {writeNOTread, address[6:0], data[31:0]}, sent MSB first.
package tcm4671_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    FETCH,
    DATA,
    FLUSH
  } state_t;

  localparam int FRAME_BITS_DEF = 40;
  localparam int WR_BIT         = 39;
  localparam int ADDR_MSB       = 38;
  localparam int ADDR_LSB       = 32;
  localparam int ADDR_BITS      = ADDR_MSB - ADDR_LSB + 1;
  localparam int DATA_BITS      = ADDR_LSB;
  localparam int HDR_BITS       = WR_BIT - ADDR_LSB + 1;

endpackage

// File: rtl/tcm4671_spi_responder_if.sv
// Register-bus side of the responder: address/data/strobes out, read data back.
// "master" is the responder, "slave" is the register file it drives.
interface tcm4671_spi_responder_if;
  import tcm4671_pkg::*;

  logic [ADDR_BITS-1:0] reg_addr;
  logic [DATA_BITS-1:0] reg_wdata;
  logic [DATA_BITS-1:0] reg_rdata;
  logic                 reg_we;
  logic                 reg_re;
  logic                 frame_done;
  logic                 frame_error;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re, frame_done, frame_error,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re, frame_done, frame_error,
    output reg_rdata
  );

endinterface

// File: rtl/tcm4671_sync.sv
// Multi-flop synchronizer for one asynchronous input plus rise/fall detection
// of the synchronized level. STAGES must be at least 1.
module tcm4671_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= {STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= STAGES'({r_chain, i_async});
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/tcm4671_spi_responder.sv
// SPI slave decoding 40-bit datagrams into single-cycle register read/write
// strobes, oversampling SCK/nSCS in the clk domain.
module tcm4671_spi_responder
  import tcm4671_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic SCK,
  input  logic nSCS,
  input  logic MOSI,
  output logic MISO,
  output logic miso_oe,
  tcm4671_spi_responder_if.master rb
);

  localparam int CNT_W    = $clog2(FRAME_BITS + 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL     = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]    CNT_HDR_LAST = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0]    CNT_SHIFT    = CNT_W'(HDR_BITS + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE  = SETTLE_W'(SYNC_STAGES);

  logic w_sck_sync, w_sck_rise_raw, w_sck_fall_raw;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_mosi, w_sck_rise, w_sck_fall;
  logic w_active, w_hdr_last, w_hdr_wr, w_frame_ok, w_settled, w_fetch_load;
  logic [ADDR_BITS-1:0] w_hdr_addr;

  state_t w_state_next;
  logic   w_we_next, w_re_next, w_done_next, w_err_next;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_mosi_chain;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_over;
  logic [SETTLE_W-1:0]    r_settle_cnt;
  logic [DATA_BITS-1:0]   r_mosi_sr;
  logic [DATA_BITS-1:0]   r_miso_sr;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DATA_BITS-1:0]   r_wdata;
  logic                   r_wr;
  logic                   r_we, r_re, r_done, r_err;

  tcm4671_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk     (clk),
    .reset   (reset),
    .i_async (SCK),
    .o_sync  (w_sck_sync),
    .o_rise  (w_sck_rise_raw),
    .o_fall  (w_sck_fall_raw)
  );

  tcm4671_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset   (reset),
    .i_async (nSCS),
    .o_sync  (w_cs_sync),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // MOSI has the same depth as SCK so the sampled bit lines up with the rise.
  always_ff @(posedge clk) begin
    if (reset) r_mosi_chain <= '0;
    else       r_mosi_chain <= SYNC_STAGES'({r_mosi_chain, MOSI});
  end
  assign w_mosi = r_mosi_chain[SYNC_STAGES-1];

  assign w_sck_rise   = w_sck_rise_raw & ~w_cs_sync;
  assign w_sck_fall   = w_sck_fall_raw & ~w_cs_sync;
  assign w_active     = (r_state == ADDR) || (r_state == FETCH) || (r_state == DATA);
  assign w_hdr_last   = (r_state == ADDR) && w_sck_rise && (r_cnt == CNT_HDR_LAST);
  assign w_hdr_wr     = r_mosi_sr[ADDR_BITS-1];
  assign w_hdr_addr   = ADDR_BITS'({r_mosi_sr, w_mosi});
  assign w_frame_ok   = (r_cnt == CNT_FULL) && !r_over;
  assign w_settled    = (r_settle_cnt == SETTLE_DONE);
  // reg_re is high in the first FETCH cycle; rdata is valid in the second.
  assign w_fetch_load = (r_state == FETCH) && !r_re;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FLUSH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_we_next    = 1'b0;
    w_re_next    = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    unique case (r_state)
      // Leave only once the synchronizers hold real pin values and the bus is idle.
      FLUSH: if (w_settled && w_cs_sync && !w_sck_sync) w_state_next = IDLE;
      IDLE:  if (w_cs_fall) w_state_next = ADDR;
      ADDR, FETCH, DATA: begin
        if (w_cs_rise) begin
          w_state_next = IDLE;
          if (w_frame_ok) begin
            w_done_next = 1'b1;
            w_we_next   = r_wr;
          end else begin
            w_err_next  = 1'b1;
          end
        end else if (w_hdr_last) begin
          if (w_hdr_wr) begin
            w_state_next = DATA;
          end else begin
            w_state_next = FETCH;
            w_re_next    = 1'b1;
          end
        end else if (w_fetch_load) begin
          w_state_next = DATA;
        end
      end
      default: w_state_next = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_over       <= 1'b0;
      r_settle_cnt <= '0;
      r_mosi_sr    <= '0;
      r_miso_sr    <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we   <= w_we_next;
      r_re   <= w_re_next;
      r_done <= w_done_next;
      r_err  <= w_err_next;
      if (r_state == FLUSH && !w_settled) r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
      if (r_state == IDLE && w_cs_fall) begin
        r_cnt     <= '0;
        r_over    <= 1'b0;
        r_mosi_sr <= '0;
        r_miso_sr <= '0;
      end
      if (w_active && w_sck_rise) begin
        if (r_cnt != CNT_FULL) begin
          r_cnt     <= r_cnt + CNT_W'(1);
          r_mosi_sr <= {r_mosi_sr[DATA_BITS-2:0], w_mosi};
        end else begin
          r_over    <= 1'b1;
        end
      end
      if (w_hdr_last) begin
        r_addr <= w_hdr_addr;
        r_wr   <= w_hdr_wr;
      end
      if (w_fetch_load) r_miso_sr <= rb.reg_rdata;
      // The fall right after the 8th rise must keep bit 31 on the line.
      if (r_state == DATA && w_sck_fall && r_cnt >= CNT_SHIFT)
        r_miso_sr <= {r_miso_sr[DATA_BITS-2:0], 1'b0};
      if (w_active && w_cs_rise) begin
        r_miso_sr <= '0;
        if (w_frame_ok && r_wr) r_wdata <= r_mosi_sr;
      end
    end
  end

  assign MISO           = r_miso_sr[DATA_BITS-1];
  assign miso_oe        = ~w_cs_sync;
  assign rb.reg_addr    = r_addr;
  assign rb.reg_wdata   = r_wdata;
  assign rb.reg_we      = r_we;
  assign rb.reg_re      = r_re;
  assign rb.frame_done  = r_done;
  assign rb.frame_error = r_err;

endmodule

// File: tb/tb_tcm4671_spi_responder.sv
// Directed bench for the SPI responder: table of whole-frame vectors plus
// hand-written reset-mid-frame and back-to-back sequences.
module tb_tcm4671_spi_responder;

  localparam int HALF = 500;   // SCK = 1 MHz against a 50 MHz clk

  logic clk = 1'b0;
  logic reset, SCK, nSCS, MOSI, MISO, miso_oe;

  tcm4671_spi_responder_if rb();

  tcm4671_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(40)) dut (
    .clk     (clk),
    .reset   (reset),
    .SCK     (SCK),
    .nSCS    (nSCS),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .miso_oe (miso_oe),
    .rb      (rb)
  );

  always #10 clk = ~clk;

  // Register file model: registered read, data valid only the cycle after reg_re.
  logic [31:0] r_rdata;
  assign rb.reg_rdata = r_rdata;

  function automatic logic [31:0] rd_model(input logic [6:0] a);
    case (a)
      7'h02:   return 32'h12345678;
      7'h10:   return 32'hA5C30F96;
      7'h11:   return 32'h0F1E2D3C;
      default: return 32'hBAD0BAD0;
    endcase
  endfunction

  always @(posedge clk) r_rdata <= rb.reg_re ? rd_model(rb.reg_addr) : $urandom;

  int n_we, n_re, n_done, n_err;
  logic [6:0]  cap_addr;
  logic [31:0] cap_wdata;

  always @(negedge clk) begin
    if (rb.reg_we) begin
      n_we++;
      cap_addr  = rb.reg_addr;
      cap_wdata = rb.reg_wdata;
    end
    if (rb.reg_re) begin
      n_re++;
      cap_addr = rb.reg_addr;
    end
    if (rb.frame_done)  n_done++;
    if (rb.frame_error) n_err++;
  end

  int n_cmp, n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_we = 0; n_re = 0; n_done = 0; n_err = 0;
    cap_addr = '0; cap_wdata = '0;
  endtask

  // Mode-0 master: MOSI changes on falls, MISO sampled just before each rise.
  task automatic spi_frame(input logic [39:0] frame, input int nbits, input int pause_ns,
                           input int rst_bit, output logic [31:0] miso_word,
                           output logic hdr_miso, output logic oe_mid);
    logic [39:0] sh;
    sh = frame;
    miso_word = '0;
    hdr_miso  = 1'b0;
    oe_mid    = 1'b0;
    MOSI = sh[39];
    nSCS = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      if (i < 8)                 hdr_miso  = hdr_miso | MISO;
      else if (i < 40)           miso_word = {miso_word[30:0], MISO};
      if (i == 4)                oe_mid    = miso_oe;
      SCK = 1'b1;
      if (i == rst_bit) begin
        #100; reset = 1'b1; #60; reset = 1'b0; #(HALF - 160);
      end else begin
        #HALF;
      end
      SCK = 1'b0;
      sh = sh << 1;
      MOSI = sh[39];
      #HALF;
      if (i == 7) #pause_ns;
    end
    nSCS = 1'b1;
    MOSI = 1'b0;
  endtask

  typedef struct {
    logic [39:0] frame;
    int          nbits;
    int          pause;
    int          exp_we;
    int          exp_re;
    int          exp_done;
    int          exp_err;
    logic [6:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    logic [31:0] mw, mw2;
    logic        hm, oe;

    n_cmp = 0; n_bad = 0;
    vecs[0] = '{40'h81DEADBEEF, 40, 0,   1, 0, 1, 0, 7'h01, 32'hDEADBEEF};
    vecs[1] = '{40'h02FFFFFFFF, 40, 500, 0, 1, 1, 0, 7'h02, 32'h12345678};
    vecs[2] = '{40'h85CAFEF00D, 20, 0,   0, 0, 0, 1, 7'h00, 32'h00000000};
    vecs[3] = '{40'h85CAFEF00D, 40, 0,   1, 0, 1, 0, 7'h05, 32'hCAFEF00D};
    vecs[4] = '{40'h8301020304, 41, 0,   0, 0, 0, 1, 7'h00, 32'h00000000};

    reset = 1'b1; SCK = 1'b0; nSCS = 1'b1; MOSI = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_miso",    64'(MISO), 64'h0);
    check("rst_oe",      64'(miso_oe), 64'h0);
    check("rst_addr",    64'(rb.reg_addr), 64'h0);
    check("rst_wdata",   64'(rb.reg_wdata), 64'h0);
    check("rst_strobes", 64'({rb.reg_we, rb.reg_re, rb.frame_done, rb.frame_error}), 64'h0);
    reset = 1'b0;
    #300;

    for (int v = 0; v < 5; v++) begin
      clear_counts();
      spi_frame(vecs[v].frame, vecs[v].nbits, vecs[v].pause, -1, mw, hm, oe);
      #1000;
      $display("vec %0d: frame=%h bits=%0d we=%0d re=%0d done=%0d err=%0d addr=%h wdata=%h miso=%h",
               v, vecs[v].frame, vecs[v].nbits, n_we, n_re, n_done, n_err, cap_addr, cap_wdata, mw);
      check($sformatf("v%0d_we", v),   64'(n_we),   64'(vecs[v].exp_we));
      check($sformatf("v%0d_re", v),   64'(n_re),   64'(vecs[v].exp_re));
      check($sformatf("v%0d_done", v), 64'(n_done), 64'(vecs[v].exp_done));
      check($sformatf("v%0d_err", v),  64'(n_err),  64'(vecs[v].exp_err));
      check($sformatf("v%0d_hdr_miso", v), 64'(hm), 64'h0);
      check($sformatf("v%0d_oe_sel", v),   64'(oe), 64'h1);
      check($sformatf("v%0d_oe_desel", v), 64'(miso_oe), 64'h0);
      if (vecs[v].exp_we != 0 || vecs[v].exp_re != 0)
        check($sformatf("v%0d_addr", v), 64'(cap_addr), 64'(vecs[v].exp_addr));
      if (vecs[v].exp_we != 0)
        check($sformatf("v%0d_wdata", v), 64'(cap_wdata), 64'(vecs[v].exp_data));
      if (vecs[v].exp_re != 0)
        check($sformatf("v%0d_miso", v), 64'(mw), 64'(vecs[v].exp_data));
    end

    // Reset pulsed during bit 15 with nSCS held low: frame silently dropped.
    clear_counts();
    spi_frame(40'h8911112222, 40, 0, 14, mw, hm, oe);
    #1000;
    $display("reset-mid-frame: we=%0d re=%0d done=%0d err=%0d addr=%h",
             n_we, n_re, n_done, n_err, rb.reg_addr);
    check("rstmid_strobes", 64'(n_we + n_re + n_done + n_err), 64'h0);
    check("rstmid_addr",    64'(rb.reg_addr), 64'h0);
    clear_counts();
    spi_frame(40'h8713572468, 40, 0, -1, mw, hm, oe);
    #1000;
    $display("after reset: we=%0d done=%0d err=%0d addr=%h wdata=%h", n_we, n_done, n_err, cap_addr, cap_wdata);
    check("postrst_we",    64'(n_we), 64'h1);
    check("postrst_done",  64'(n_done), 64'h1);
    check("postrst_addr",  64'(cap_addr), 64'h07);
    check("postrst_wdata", 64'(cap_wdata), 64'h13572468);

    // Back-to-back reads separated by one SCK period of deselect.
    clear_counts();
    spi_frame(40'h1000000000, 40, 0, -1, mw, hm, oe);
    #1000;
    spi_frame(40'h1100000000, 40, 0, -1, mw2, hm, oe);
    #1000;
    $display("b2b reads: re=%0d done=%0d err=%0d miso0=%h miso1=%h", n_re, n_done, n_err, mw, mw2);
    check("b2b_re",    64'(n_re), 64'h2);
    check("b2b_done",  64'(n_done), 64'h2);
    check("b2b_err",   64'(n_err), 64'h0);
    check("b2b_miso0", 64'(mw), 64'hA5C30F96);
    check("b2b_miso1", 64'(mw2), 64'h0F1E2D3C);

    // Back-to-back writes with a 40 ns (two clk) deselect gap.
    clear_counts();
    spi_frame(40'h8A11223344, 40, 0, -1, mw, hm, oe);
    #40;
    spi_frame(40'h8B55667788, 40, 0, -1, mw, hm, oe);
    #1000;
    $display("tight writes: we=%0d done=%0d err=%0d addr=%h wdata=%h", n_we, n_done, n_err, cap_addr, cap_wdata);
    check("tight_we",    64'(n_we), 64'h2);
    check("tight_err",   64'(n_err), 64'h0);
    check("tight_addr",  64'(cap_addr), 64'h0B);
    check("tight_wdata", 64'(cap_wdata), 64'h55667788);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
